// File: rtl/rr_mux4_pkg.sv
// +----------------------------------------------------------------------+
// | rr_mux4_pkg : shared lane constants, index type and rotation helper  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package rr_mux4_pkg;

   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;

   typedef logic [SEL_W-1:0] lane_idx_t;

   // Modulo-4 wrap comes for free from the 2-bit index width.
   function automatic lane_idx_t next_lane(input lane_idx_t idx);
      return idx + lane_idx_t'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb4.sv
// +----------------------------------------------------------------------+
// | rr_arb4  : combinational 4-way round-robin picker, starts after ptr  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arb4
   import rr_mux4_pkg::*;
(
   input  logic [NUM_LANES-1:0] req,
   input  lane_idx_t            ptr,
   output lane_idx_t            grant,
   output logic                 any_valid
);

   lane_idx_t w_idx;

   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      w_idx     = ptr;
      for (int k = 0; k < NUM_LANES; k++) begin
         w_idx = next_lane(w_idx);
         if (!any_valid && req[w_idx]) begin
            grant     = w_idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rr_mux4_tx.sv
// +----------------------------------------------------------------------+
// | rr_mux4_tx : round-robin 4-lane combiner with registered out/select. |
// | Optional stats port via macro RR_MUX4_TX_STATS_EN.                   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_mux4_tx
   import rr_mux4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data0,
   input  logic [WIDTH-1:0]     in_data1,
   input  logic [WIDTH-1:0]     in_data2,
   input  logic [WIDTH-1:0]     in_data3,
   input  logic [NUM_LANES-1:0] in_valid,
   output logic [NUM_LANES-1:0] in_ready,
   output logic [WIDTH-1:0]     out,
   output logic                 s0,
   output logic                 s1,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef RR_MUX4_TX_STATS_EN
   ,
   output logic [15:0]          beat_cnt,
   output logic [SEL_W-1:0]     lane_last
`endif
);

   logic [WIDTH-1:0] out_q, out_d;
   lane_idx_t        sel_q, sel_d;
   logic             valid_q, valid_d;
   lane_idx_t        ptr_q, ptr_d;

   lane_idx_t        w_grant;
   logic             w_any_valid;
   logic             w_load_en;
   logic [WIDTH-1:0] w_win_data;

   rr_arb4 u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .grant     (w_grant),
      .any_valid (w_any_valid)
   );

   always_comb begin
      case (w_grant)
         2'd0:    w_win_data = in_data0;
         2'd1:    w_win_data = in_data1;
         2'd2:    w_win_data = in_data2;
         default: w_win_data = in_data3;
      endcase
   end

   assign w_load_en = !valid_q || out_ready;

   // Gated by rst so nothing is accepted while the link is held in reset.
   always_comb begin
      in_ready = '0;
      if (w_load_en && w_any_valid && !rst)
         in_ready = 4'b0001 << w_grant;
   end

   always_comb begin
      out_d   = out_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (w_load_en) begin
         valid_d = w_any_valid;
         if (w_any_valid) begin
            out_d = w_win_data;
            sel_d = w_grant;
            ptr_d = w_grant;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= 2'd3;
      end else begin
         out_q   <= out_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out       = out_q;
   assign s0        = sel_q[1];
   assign s1        = sel_q[0];
   assign out_valid = valid_q;

`ifdef RR_MUX4_TX_STATS_EN
   logic [15:0] beat_cnt_q, beat_cnt_d;
   lane_idx_t   lane_last_q, lane_last_d;

   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      lane_last_d = lane_last_q;
      if (valid_q && out_ready) begin
         beat_cnt_d  = beat_cnt_q + 16'd1;
         lane_last_d = sel_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         lane_last_q <= '0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         lane_last_q <= lane_last_d;
      end
   end

   assign beat_cnt  = beat_cnt_q;
   assign lane_last = lane_last_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_mux4_tx.sv
// +----------------------------------------------------------------------+
// | tb_rr_mux4_tx : randomized + directed bench for rr_mux4_tx with a    |
// | lane-rotation reference model. Revision : 1.0                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rr_mux4_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] lane_data [4];
   logic [3:0] in_valid = '0;
   logic [3:0] in_ready;
   logic [7:0] out;
   logic       s0, s1, out_valid;
   logic       out_ready = 1'b0;
`ifdef RR_MUX4_TX_STATS_EN
   logic [15:0] beat_cnt;
   logic [1:0]  lane_last;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int         m_ptr;
   bit         m_valid;
   logic [7:0] m_out;
   logic [1:0] m_sel;
   int         m_cnt;
   logic [1:0] m_last;

   always #5 clk = ~clk;

   rr_mux4_tx #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data0  (lane_data[0]),
      .in_data1  (lane_data[1]),
      .in_data2  (lane_data[2]),
      .in_data3  (lane_data[3]),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .s0        (s0),
      .s1        (s1),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef RR_MUX4_TX_STATS_EN
      ,
      .beat_cnt  (beat_cnt),
      .lane_last (lane_last)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int winner();
      for (int k = 1; k <= 4; k++)
         if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 3; m_valid = 0; m_out = 8'h00; m_sel = 2'd0; m_cnt = 0; m_last = 2'd0;
   endtask

   // Called at a negedge with inputs already set; returns at the next negedge.
   task automatic tick();
      int         w;
      bit         ld;
      logic [3:0] er;
      w  = winner();
      ld = !m_valid || out_ready;
      er = (ld && w >= 0) ? 4'(1 << w) : 4'd0;
      #1 chk("in_ready", {28'd0, in_ready}, {28'd0, er});
      @(posedge clk);
      if (m_valid && out_ready) begin
         m_cnt++;
         m_last = m_sel;
      end
      if (ld) begin
         if (w >= 0) begin
            m_out = lane_data[w]; m_sel = 2'(w); m_valid = 1; m_ptr = w;
         end else begin
            m_valid = 0;
         end
      end
      @(negedge clk);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out", {24'd0, out}, {24'd0, m_out});
      chk("sel", {30'd0, s0, s1}, {30'd0, m_sel});
`ifdef RR_MUX4_TX_STATS_EN
      chk("beat_cnt", {16'd0, beat_cnt}, 32'(m_cnt % 65536));
      chk("lane_last", {30'd0, lane_last}, {30'd0, m_last});
`endif
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out", {24'd0, out}, 32'd0);
      chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
      chk("rst_sel", {30'd0, s0, s1}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] held;
      for (int i = 0; i < 4; i++) lane_data[i] = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out", {24'd0, out}, 32'd0);

      // Single lane 2
      in_valid = 4'b0100; lane_data[2] = 8'hA5; out_ready = 1'b1;
      tick();
      chk("single_out", {24'd0, out}, 32'hA5);
      chk("single_s0s1", {30'd0, s0, s1}, 32'd2);
      tick(); tick();

      // All lanes, fair rotation from reset
      do_reset();
      for (int i = 0; i < 4; i++) lane_data[i] = 8'h10 + 8'(i);
      in_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rot_out", {24'd0, out}, 32'h10 + 32'(i % 4));
         chk("rot_sel", {30'd0, s0, s1}, 32'(i % 4));
      end

      // Backpressure: hold three cycles, then resume at lane 1
      out_ready = 1'b0;
      held = out;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold", {24'd0, out}, {24'd0, held});
      end
      out_ready = 1'b1;
      tick();
      chk("bp_resume", {24'd0, out}, 32'h11);

      // Skip idle lanes after a lane-0 grant
      do_reset();
      in_valid = 4'b0001;
      tick();
      in_valid = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("skip_sel", {30'd0, s0, s1}, (i % 2 == 0) ? 32'd3 : 32'd0);
      end

      // Reset mid-transfer, then first grant must be lane 0
      out_ready = 1'b0;
      in_valid  = 4'b1110;
      tick();
      do_reset();
      in_valid = 4'b1111;
      tick();
      chk("post_rst_sel", {30'd0, s0, s1}, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < 4; i++) lane_data[i] = 8'($urandom);
         tick();
      end

`ifdef RR_MUX4_TX_STATS_EN
      do_reset();
      in_valid = 4'b1111; out_ready = 1'b1;
      for (int n = 0; n < 70001; n++) tick();
      chk("beat_cnt_wrap", {16'd0, beat_cnt}, 32'd4464);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
